// File: rtl/reg_file_sb.sv
// Architectural register file at the MEM/WB writeback boundary: two combinational
// read ports with write bypass, hardwired x0, and a per-register pending-write scoreboard.
module reg_file_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy2,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  output logic              sb_err
);

  localparam int NREG    = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              err_q, err_d;
  logic              wb_fire, hit1, hit2;

  // A stalled pipeline neither commits nor forwards the writeback.
  assign wb_fire = rdy_in && wb_we;
  assign hit1    = wb_fire && (wb_addr == raddr1);
  assign hit2    = wb_fire && (wb_addr == raddr2);
  assign sb_err  = err_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_fire && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Mark, writeback and kill combine into one signed delta per register, then clamp.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      int net;
      net      = int'(cnt_q[r]);
      cnt_d[r] = cnt_q[r];
      if (rdy_in && r != 0) begin
        if (mark_en && mark_addr == ADDR_W'(r)) net = net + 1;
        if (wb_we && wb_addr == ADDR_W'(r))     net = net - 1;
        if (kill_en && kill_addr == ADDR_W'(r)) net = net - 1;
        if (net > CNT_MAX) begin
          cnt_d[r] = CNT_W'(CNT_MAX);
          err_d    = 1'b1;
        end else if (net < 0) begin
          cnt_d[r] = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d[r] = CNT_W'(net);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

  // A writeback landing this cycle retires one pending write and supplies the data.
  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (rst_in && re1 && raddr1 != '0) begin
      rdata1 = hit1 ? wb_data : regs_q[raddr1];
      busy1  = hit1 ? (cnt_q[raddr1] > CNT_W'(1)) : (cnt_q[raddr1] != '0);
    end
  end

  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (rst_in && re2 && raddr2 != '0) begin
      rdata2 = hit2 ? wb_data : regs_q[raddr2];
      busy2  = hit2 ? (cnt_q[raddr2] > CNT_W'(1)) : (cnt_q[raddr2] != '0);
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Architectural register file: the receiving end of the MEM/WB writeback interface.
- Accepts the writeback triple (address, data, write-enable) from the MEM/WB pipeline register.
- Serves two combinational read ports to ID, with same-cycle write bypass and hardwired x0.
- Holds a per-register pending-write scoreboard (small counters) so ID can detect RAW hazards on in-flight results.

Parameters:
- ADDR_W, 5, register address width (2^ADDR_W registers).
- DATA_W, 32, register data width.
- CNT_W, 2, width of each pending-write counter (max 2^CNT_W-1 in-flight writes per register).

Ports:
- clk_in  in  1  system clock, all state updates on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; when 0, no state changes (reads stay combinational)
- wb_we  in  1  writeback enable (from MEM/WB if_write_out)
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- busy1  out  1  raddr1 has an outstanding write not yet available
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- busy2  out  1  raddr2 has an outstanding write not yet available
- mark_en  in  1  ID issues an instruction that will write mark_addr
- mark_addr  in  ADDR_W  destination being marked
- kill_en  in  1  a marked instruction was squashed before writeback
- kill_addr  in  ADDR_W  destination of the squashed instruction
- sb_err  out  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Reset (rst_in=0, async):
  - All registers and all counters become 0.
  - sb_err becomes 0.
  - rdata1/2 = 0 and busy1/2 = 0 while reset is held.
- Write:
  - On posedge with rdy_in=1, wb_we=1, wb_addr!=0: reg[wb_addr] <= wb_data.
  - Writes to x0 are dropped.
- Read (port n, combinational):
  - rdata = 0 if re=0 or raddr=0.
  - Else wb_data if rdy_in=1, wb_we=1 and wb_addr==raddr (bypass).
  - Else reg[raddr].
- Counter update (per register r, on posedge with rdy_in=1; x0 never counted):
  - inc = mark_en && mark_addr==r.
  - dec = (wb_we && wb_addr==r) + (kill_en && kill_addr==r); range 0..2.
  - cnt[r] <= cnt[r] + inc - dec, applied as one net update.
  - Simultaneous mark and writeback on the same register: net 0.
- Overflow: net result > 2^CNT_W-1.
  - Counter saturates at max; sb_err <= 1.
- Underflow: net result < 0.
  - Counter clamps to 0; sb_err <= 1.
  - Covers wb_we to a register with cnt=0.
- sb_err clears only on reset.
- busy (port n):
  - busy = re && raddr!=0 && eff_cnt(raddr) != 0.
  - eff_cnt = cnt − (1 if rdy_in && wb_we && wb_addr==raddr, else 0), evaluated combinationally.
  - Data arriving this cycle is therefore bypassed, not reported busy.
  - A mark in the current cycle does not affect busy until the next cycle.
- rdy_in=0: registers, counters and sb_err hold. Bypass and eff_cnt adjustment are disabled, so reads return stored values.
- Reset asserted mid-operation: immediate clear. No pending write survives; the first edge after release behaves normally.

Test Plan:
- Write and read: reset, then wb_we=1 wb_addr=5 wb_data=0xDEADBEEF for 1 cycle.
  - Next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF, busy1=0.
- x0 and bypass:
  - wb_we=1 wb_addr=0 wb_data=0x1234, then read x0 -> rdata=0.
  - Same cycle as wb_we=1 wb_addr=7 wb_data=0xA5A5A5A5, raddr2=7 -> rdata2=0xA5A5A5A5 combinationally.
- Scoreboard lifecycle:
  - mark x3 at cycle 0 -> busy1(raddr1=3)=1 from cycle 1.
  - Writeback x3=0x42 at cycle 3 -> busy1=0 and rdata1=0x42 in cycle 3.
  - cnt[3]=0 after the edge.
- Two in-flight writers: mark x9 twice, then one writeback -> busy stays 1. After the second writeback -> 0.
- Simultaneous events:
  - mark and writeback x4 on the same edge with cnt[4]=1 -> cnt stays 1, busy=1.
  - kill x4 next -> busy=0.
- Errors and stall:
  - 4 marks of x6 -> sb_err=1, cnt=3.
  - Writeback with cnt=0 -> sb_err=1.
  - rdy_in=0 during a write -> register unchanged, no bypass.
  - Async reset mid-stream -> all outputs 0 without a clock edge.
